// File: rtl/prog_sequencer.sv
// Program sequencer: owns the PC and IDLE/RUN/DONE run control, detects the halt word,
// resolves relative/absolute branches and keeps saturating cycle and retired-instruction counters.
module prog_sequencer #(
    parameter int unsigned        PC_W       = 10,
    parameter int unsigned        INST_W     = 9,
    parameter int unsigned        CNT_W      = 16,
    parameter logic [INST_W-1:0]  HALT_WORD  = '0,
    parameter logic [PC_W-1:0]    START_ADDR = '0
) (
    input  logic              clk,
    input  logic              init,
    input  logic              req,
    input  logic              stall,
    input  logic              branch_en,
    input  logic              branch_flag,
    input  logic              branch_abs,
    input  logic [PC_W-1:0]   target,
    input  logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   pc,
    output logic              busy,
    output logic              ack,
    output logic [CNT_W-1:0]  cycle_ct,
    output logic [CNT_W-1:0]  inst_ct
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  w_pc_nxt;
    logic [PC_W-1:0]  w_pc_retire;
    logic [CNT_W-1:0] r_cyc;
    logic [CNT_W-1:0] w_cyc_nxt;
    logic [CNT_W-1:0] w_cyc_inc;
    logic [CNT_W-1:0] r_ic;
    logic [CNT_W-1:0] w_ic_nxt;
    logic [CNT_W-1:0] w_ic_inc;
    logic             w_taken;

    always_ff @(posedge clk) begin
        if (init) begin
            r_state <= S_IDLE;
            r_pc    <= START_ADDR;
            r_cyc   <= '0;
            r_ic    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_cyc   <= w_cyc_nxt;
            r_ic    <= w_ic_nxt;
        end
    end

    // Same-width addition wraps modulo 2^PC_W, which equals adding the sign-extended offset.
    always_comb begin
        w_taken     = branch_en & branch_flag;
        w_cyc_inc   = (r_cyc == '1) ? r_cyc : r_cyc + CNT_W'(1);
        w_ic_inc    = (r_ic == '1) ? r_ic : r_ic + CNT_W'(1);
        if (w_taken && branch_abs) begin
            w_pc_retire = target;
        end else if (w_taken) begin
            w_pc_retire = r_pc + target;
        end else begin
            w_pc_retire = r_pc + PC_W'(1);
        end

        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cyc_nxt   = r_cyc;
        w_ic_nxt    = r_ic;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (req) begin
                    w_state_nxt = S_RUN;
                    w_pc_nxt    = START_ADDR;
                    w_cyc_nxt   = '0;
                    w_ic_nxt    = '0;
                end
            end
            S_RUN: begin
                if (req) begin
                    w_pc_nxt  = START_ADDR;
                    w_cyc_nxt = '0;
                    w_ic_nxt  = '0;
                end else if (stall) begin
                    w_cyc_nxt = w_cyc_inc;
                end else if (inst == HALT_WORD) begin
                    w_state_nxt = S_DONE;
                    w_cyc_nxt   = w_cyc_inc;
                end else begin
                    w_pc_nxt  = w_pc_retire;
                    w_cyc_nxt = w_cyc_inc;
                    w_ic_nxt  = w_ic_inc;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign pc       = r_pc;
    assign busy     = (r_state == S_RUN);
    assign ack      = (r_state == S_DONE);
    assign cycle_ct = r_cyc;
    assign inst_ct  = r_ic;

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: vector table on the default configuration,
// plus hand sequences for counter saturation (CNT_W=4) and a non-default parameter set.
module tb_prog_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nchecks = 0;
    int nerrors = 0;

    // ---------------- default-parameter DUT ----------------
    logic        init0, req0, stall0, ben0, bfl0, babs0;
    logic [9:0]  tgt0;
    logic [8:0]  inst0;
    logic [9:0]  pc0;
    logic        busy0, ack0;
    logic [15:0] cyc0, ic0;
    logic [8:0]  rom0 [1024];

    assign inst0 = rom0[pc0];

    prog_sequencer u0 (
        .clk(clk), .init(init0), .req(req0), .stall(stall0),
        .branch_en(ben0), .branch_flag(bfl0), .branch_abs(babs0), .target(tgt0),
        .inst(inst0), .pc(pc0), .busy(busy0), .ack(ack0),
        .cycle_ct(cyc0), .inst_ct(ic0)
    );

    // ---------------- CNT_W=4 DUT for saturation ----------------
    logic        init1, req1, stall1;
    logic [9:0]  pc1;
    logic        busy1, ack1;
    logic [3:0]  cyc1, ic1;
    logic [9:0]  tgt1 = 10'd2;
    logic [8:0]  inst1 = 9'h1;
    logic        one1 = 1'b1;

    prog_sequencer #(.CNT_W(4)) u1 (
        .clk(clk), .init(init1), .req(req1), .stall(stall1),
        .branch_en(one1), .branch_flag(one1), .branch_abs(one1), .target(tgt1),
        .inst(inst1), .pc(pc1), .busy(busy1), .ack(ack1),
        .cycle_ct(cyc1), .inst_ct(ic1)
    );

    // ---------------- wide / non-zero halt DUT ----------------
    logic        init2, req2;
    logic [11:0] pc2;
    logic        busy2, ack2;
    logic [15:0] cyc2, ic2;
    logic [15:0] inst2;
    logic [15:0] rom2 [4096];
    logic        zero2 = 1'b0;
    logic [11:0] tgt2 = '0;

    assign inst2 = rom2[pc2];

    prog_sequencer #(.PC_W(12), .INST_W(16), .HALT_WORD(16'hFFFF), .START_ADDR(12'h100)) u2 (
        .clk(clk), .init(init2), .req(req2), .stall(zero2),
        .branch_en(zero2), .branch_flag(zero2), .branch_abs(zero2), .target(tgt2),
        .inst(inst2), .pc(pc2), .busy(busy2), .ack(ack2),
        .cycle_ct(cyc2), .inst_ct(ic2)
    );

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic init, req, stall, ben, bfl, babs;
        int   tgt;
        int   pc;
        logic busy, ack;
        int   cyc, ic;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic in_, rq, st, be, bf, ba, input int tg,
                       input int p, input logic b, a, input int c, ic);
        vec_t v;
        v.init = in_; v.req = rq; v.stall = st;
        v.ben = be; v.bfl = bf; v.babs = ba; v.tgt = tg;
        v.pc = p; v.busy = b; v.ack = a; v.cyc = c; v.ic = ic;
        vq.push_back(v);
    endtask

    // Plain step: no control inputs asserted.
    task automatic nop(input int p, input logic b, a, input int c, ic);
        add(0, 0, 0, 0, 0, 0, 0, p, b, a, c, ic);
    endtask

    task automatic run_vecs(input string tag);
        foreach (vq[k]) begin
            init0 = vq[k].init; req0 = vq[k].req; stall0 = vq[k].stall;
            ben0 = vq[k].ben; bfl0 = vq[k].bfl; babs0 = vq[k].babs;
            tgt0 = 10'(vq[k].tgt);
            tick();
            check($sformatf("%s[%0d].pc", tag, k), 32'(pc0), 32'(vq[k].pc));
            check($sformatf("%s[%0d].busy", tag, k), 32'(busy0), 32'(vq[k].busy));
            check($sformatf("%s[%0d].ack", tag, k), 32'(ack0), 32'(vq[k].ack));
            check($sformatf("%s[%0d].cycle_ct", tag, k), 32'(cyc0), 32'(vq[k].cyc));
            check($sformatf("%s[%0d].inst_ct", tag, k), 32'(ic0), 32'(vq[k].ic));
        end
        vq.delete();
        init0 = 0; req0 = 0; stall0 = 0; ben0 = 0; bfl0 = 0; babs0 = 0; tgt0 = '0;
    endtask

    initial begin
        init0 = 0; req0 = 0; stall0 = 0; ben0 = 0; bfl0 = 0; babs0 = 0; tgt0 = '0;
        init1 = 0; req1 = 0; stall1 = 0;
        init2 = 0; req2 = 0;
        for (int i = 0; i < 1024; i++) rom0[i] = 9'((i % 500) + 1);
        rom0[5]  = '0;
        rom0[50] = '0;
        for (int i = 0; i < 4096; i++) rom2[i] = 16'h0000;
        rom2[12'h103] = 16'hFFFF;

        // Reset with req/stall asserted, then idle without req.
        add(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nop(0, 0, 0, 0, 0);
        nop(0, 0, 0, 0, 0);
        nop(0, 0, 0, 0, 0);
        // Straight-line: 5 instructions then halt at address 5.
        add(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        nop(1, 1, 0, 1, 1);
        nop(2, 1, 0, 2, 2);
        nop(3, 1, 0, 3, 3);
        nop(4, 1, 0, 4, 4);
        nop(5, 1, 0, 5, 5);
        nop(5, 0, 1, 6, 5);
        nop(5, 0, 1, 6, 5);
        nop(5, 0, 1, 6, 5);
        // Branches; the req also checks ack falling from DONE.
        add(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        nop(1, 1, 0, 1, 1);
        nop(2, 1, 0, 2, 2);
        nop(3, 1, 0, 3, 3);
        add(0, 0, 0, 1, 1, 0, 'h3FE, 1, 1, 0, 4, 4);
        add(0, 0, 0, 1, 1, 1, 20, 20, 1, 0, 5, 5);
        add(0, 0, 0, 1, 0, 0, 5, 21, 1, 0, 6, 6);
        add(0, 0, 0, 0, 1, 0, 100, 22, 1, 0, 7, 7);
        add(0, 0, 0, 1, 1, 1, 1023, 1023, 1, 0, 8, 8);
        add(0, 0, 0, 1, 1, 0, 1, 0, 1, 0, 9, 9);
        add(0, 0, 0, 1, 1, 1, 1023, 1023, 1, 0, 10, 10);
        nop(0, 1, 0, 11, 11);
        add(0, 0, 0, 1, 1, 1, 50, 50, 1, 0, 12, 12);
        add(0, 0, 0, 1, 1, 1, 7, 50, 0, 1, 13, 12);
        run_vecs("basic");

        // 3-instruction program: halt now at address 3.
        rom0[3] = '0;
        add(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        nop(1, 1, 0, 1, 1);
        for (int s = 0; s < 4; s++) add(0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 2 + s, 1);
        nop(2, 1, 0, 6, 2);
        nop(3, 1, 0, 7, 3);
        nop(3, 0, 1, 8, 3);
        // Stall held over the halt word.
        add(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        nop(1, 1, 0, 1, 1);
        nop(2, 1, 0, 2, 2);
        nop(3, 1, 0, 3, 3);
        add(0, 0, 1, 0, 0, 0, 0, 3, 1, 0, 4, 3);
        add(0, 0, 1, 0, 0, 0, 0, 3, 1, 0, 5, 3);
        nop(3, 0, 1, 6, 3);
        // Restart mid-RUN, req held two cycles.
        add(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        nop(1, 1, 0, 1, 1);
        nop(2, 1, 0, 2, 2);
        add(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        nop(1, 1, 0, 1, 1);
        // init mid-RUN.
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nop(0, 0, 0, 0, 0);
        nop(0, 0, 0, 0, 0);
        run_vecs("stall");

        // Saturation: cycle_ct saturates first, inst_ct keeps counting.
        init1 = 1; tick();
        init1 = 0; req1 = 1; tick();
        req1 = 0;
        check("sat.start_pc", 32'(pc1), 32'd0);
        check("sat.start_cyc", 32'(cyc1), 32'd0);
        stall1 = 1;
        for (int i = 0; i < 10; i++) tick();
        check("sat.stall_pc", 32'(pc1), 32'd0);
        check("sat.stall_cyc", 32'(cyc1), 32'd10);
        check("sat.stall_ic", 32'(ic1), 32'd0);
        stall1 = 0;
        for (int i = 0; i < 5; i++) tick();
        check("sat.cyc15", 32'(cyc1), 32'd15);
        check("sat.ic5", 32'(ic1), 32'd5);
        check("sat.pc_loop", 32'(pc1), 32'd2);
        for (int i = 0; i < 5; i++) tick();
        check("sat.cyc_hold", 32'(cyc1), 32'd15);
        check("sat.ic10", 32'(ic1), 32'd10);
        for (int i = 0; i < 10; i++) tick();
        check("sat.cyc_final", 32'(cyc1), 32'd15);
        check("sat.ic_final", 32'(ic1), 32'd15);
        check("sat.pc_final", 32'(pc1), 32'd2);
        check("sat.busy", 32'(busy1), 32'd1);
        req1 = 1; tick(); req1 = 0;
        check("sat.restart_pc", 32'(pc1), 32'd0);
        check("sat.restart_cyc", 32'(cyc1), 32'd0);
        check("sat.restart_ic", 32'(ic1), 32'd0);

        // Non-default parameters: START_ADDR=0x100, halt on 0xFFFF only.
        init2 = 1; tick(); init2 = 0;
        check("par.reset_pc", 32'(pc2), 32'h100);
        req2 = 1; tick(); req2 = 0;
        check("par.start_pc", 32'(pc2), 32'h100);
        check("par.start_busy", 32'(busy2), 32'd1);
        tick();
        check("par.zero_word_pc", 32'(pc2), 32'h101);
        check("par.zero_word_ic", 32'(ic2), 32'd1);
        tick(); tick();
        check("par.pre_halt_pc", 32'(pc2), 32'h103);
        check("par.pre_halt_ack", 32'(ack2), 32'd0);
        tick();
        check("par.halt_ack", 32'(ack2), 32'd1);
        check("par.halt_pc", 32'(pc2), 32'h103);
        check("par.halt_cyc", 32'(cyc2), 32'd4);
        check("par.halt_ic", 32'(ic2), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Parametrised program sequencer that replaces the fixed-width instruction fetch, halt/ack detection and cycle counting of the basic processor top level. It owns the program counter and a three-state run control (IDLE/RUN/DONE). Each RUN cycle it presents a PC to the instruction ROM and decodes the returned word for halt. It supports relative or absolute branches, pipeline stall, a registered start/done handshake, and saturating cycle and retired-instruction counters. It sits between the control decoder/ALU (branch inputs) and the instruction ROM.

## Interface
- PC_W, 10, program counter width in bits; ROM depth is 2^PC_W
- INST_W, 9, instruction word width
- CNT_W, 16, width of both performance counters
- HALT_WORD, 0, instruction encoding that terminates a program
- START_ADDR, 0, PC value loaded at program start (PC_W bits)
- clk  in  1  clock; all state changes on posedge
- init  in  1  reset, synchronous, active-high
- req  in  1  start/restart program; sampled at posedge
- stall  in  1  hold PC and do not retire current instruction
- branch_en  in  1  current instruction is a branch
- branch_flag  in  1  branch condition from ALU; taken = branch_en & branch_flag
- branch_abs  in  1  0: PC-relative, 1: absolute target
- target  in  PC_W  branch offset (two's complement) or absolute address
- inst  in  INST_W  instruction word returned by ROM for current pc (combinational ROM)
- pc  out  PC_W  registered program counter, drives ROM address
- busy  out  1  high while in RUN
- ack  out  1  registered done flag, high in DONE
- cycle_ct  out  CNT_W  cycles spent in RUN for current/last program
- inst_ct  out  CNT_W  instructions retired (excluding halt) for current/last program

## Operation
- States: IDLE, RUN, DONE; encoding free. busy = (state==RUN), ack = (state==DONE).
- Reset (init=1): state IDLE, pc=START_ADDR, cycle_ct=0, inst_ct=0, busy=0, ack=0. init overrides every other input, including mid-program.
- IDLE: req=1 -> RUN; pc<=START_ADDR, both counters <=0. req=0 -> stay; all outputs hold.
- RUN, evaluated in priority order:
  - req=1: restart; pc<=START_ADDR, counters<=0, stay RUN.
  - stall=1: pc holds, inst_ct holds, cycle_ct increments; halt is not evaluated.
  - inst==HALT_WORD: -> DONE; pc holds; cycle_ct increments; inst_ct holds. Branch inputs are ignored.
  - otherwise retire: inst_ct increments, cycle_ct increments, and pc updates to:
    - taken & ~branch_abs: pc + sign-extended target, modulo 2^PC_W.
    - taken & branch_abs: target.
    - not taken: pc+1 modulo 2^PC_W. pc = 2^PC_W-1 wraps to 0.
- DONE: pc and counters frozen. req=1 -> RUN with the same reload as IDLE.
- Counters saturate at 2^CNT_W-1 and never wrap. Saturation of one counter does not affect the other or the PC.
- Combinational ROM path: inst belongs to the current pc in the same cycle.

## Timing
- req high at edge N: busy=1, pc=START_ADDR and counters=0 visible after edge N. First instruction is evaluated in cycle N..N+1.
- Straight-line program of K instructions followed by HALT_WORD, with no stalls:
  - ack rises after edge N+K+1.
  - cycle_ct=K+1, inst_ct=K.
- Each stall cycle adds exactly 1 to the cycles to ack and to cycle_ct. It adds 0 to inst_ct.
- Branch takes effect at the next edge; there is no delay slot.
- ack stays high until the edge where req=1 (falls after that edge) or init=1.
- req and init are level-sampled; a req held high for multiple cycles restarts every cycle.

## Test plan
- Reset: drive init=1 for 2 cycles with req=1 and stall=1. Required: pc=0, ack=0, busy=0, counters=0. init=0 with req=0 stays IDLE indefinitely.
- Straight-line: ROM holds 5 non-zero words, then 0 at addr 5; req pulse 1 cycle. Required:
  - pc runs 0,1,2,3,4,5 and holds at 5.
  - ack rises 6 edges after req; cycle_ct=6, inst_ct=5.
  - ack stays high until the next req.
- Branches (PC_W=10): at pc=3 with taken relative target=10'h3FE (-2), next pc=1. At pc=1 with taken absolute target=20, next pc=20. With branch_en=1, branch_flag=0, next pc=pc+1. Relative +1 from pc=1023 gives 0.
- Stall: 3-instruction program with stall=1 for 4 cycles at pc=1. Required: pc holds at 1 during the stall, inst_ct=3, cycle_ct=8, ack 4 cycles later than the unstalled run. Stall asserted while inst==HALT_WORD delays ack until stall drops.
- Restart and saturation (CNT_W=4): an endless loop (pc=2 branches to 2) saturates cycle_ct and inst_ct at 15 with pc stable. A req mid-RUN reloads pc=START_ADDR and clears both counters on that edge. init mid-RUN returns to IDLE.
- Parameters: PC_W=12, INST_W=16, HALT_WORD=16'hFFFF, START_ADDR=12'h100. Required: start at 0x100, word 0x0000 executes as a normal instruction, halt only on 0xFFFF.
